// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: read-side sequencer for the PS/2 keyboard receiver FIFO.
// Pops scan-code bytes, folds E0/F0/E1 prefixes into single key events,
// tracks the currently held key and counts reported key presses.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   en            1 = allowed to pop receiver bytes (decode state is kept)
//   kb_data       receiver FIFO head byte, valid while kb_ready=1
//   kb_ready      receiver FIFO non-empty
//   kb_overflow   receiver sticky overflow flag
//   kb_read_n     registered active-low one-cycle pop strobe
//   key_valid     one-cycle pulse, key_code/key_ext/key_release valid
//   key_code      scan code of the event with prefixes stripped
//   key_ext       event carried an E0 prefix
//   key_release   1 = break event, 0 = make event
//   key_down      a key is currently held
//   held_code     scan code of the held key
//   press_count   reported make events, modulo 2^CNT_W
//   ovf_seen      sticky, kb_overflow seen high since reset
//
// Optional build macro PS2_TYPEMATIC_FILTER_EN: when defined, auto-repeat
// makes of the already-held key are swallowed (popped but not reported).

module ps2_kbd_ctrl #(
    parameter int unsigned E1_SKIP = 7,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [7:0]       kb_data,
    input  logic             kb_ready,
    input  logic             kb_overflow,
    output logic             kb_read_n,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_release,
    output logic             key_down,
    output logic [7:0]       held_code,
    output logic [CNT_W-1:0] press_count,
    output logic             ovf_seen
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_POP  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam int unsigned SKIP_W =
        (E1_SKIP < 1) ? 1 : $clog2(E1_SKIP + 1);

    localparam logic [7:0] B_E0 = 8'hE0;
    localparam logic [7:0] B_E1 = 8'hE1;
    localparam logic [7:0] B_F0 = 8'hF0;

    logic [1:0]        state_q, state_d;
    logic [7:0]        byte_q, byte_d;
    logic              rd_n_q, rd_n_d;
    logic              ext_q, ext_d;
    logic              brk_q, brk_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic              vld_q, vld_d;
    logic [7:0]        code_q, code_d;
    logic              kext_q, kext_d;
    logic              rel_q, rel_d;
    logic              down_q, down_d;
    logic [7:0]        hcode_q, hcode_d;
    logic              hext_q, hext_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    // Held key equals the byte being decoded, including the E0 flag.
    logic held_match;
    // Event would be reported (cleared only for filtered auto-repeat).
    logic report;

    assign held_match = (hcode_q == byte_q) && (hext_q == ext_q);

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign report = brk_q || !(down_q && held_match);
`else
    assign report = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        rd_n_d  = 1'b1;
        ext_d   = ext_q;
        brk_d   = brk_q;
        skip_d  = skip_q;
        vld_d   = 1'b0;
        code_d  = code_q;
        kext_d  = kext_q;
        rel_d   = rel_q;
        down_d  = down_q;
        hcode_d = hcode_q;
        hext_d  = hext_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q | kb_overflow;

        case (state_q)
            S_IDLE: begin
                if (en && kb_ready) begin
                    byte_d  = kb_data;
                    rd_n_d  = 1'b0;
                    state_d = S_POP;
                end
            end

            S_POP: begin
                state_d = S_GAP;
                if (skip_q != '0) begin
                    // Pause sequence body: drop without decoding.
                    skip_d = skip_q - SKIP_W'(1);
                end else if (byte_q == B_E1) begin
                    skip_d = SKIP_W'(E1_SKIP);
                    ext_d  = 1'b0;
                    brk_d  = 1'b0;
                end else if (byte_q == B_E0) begin
                    ext_d = 1'b1;
                end else if (byte_q == B_F0) begin
                    brk_d = 1'b1;
                end else begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                    if (report) begin
                        vld_d  = 1'b1;
                        code_d = byte_q;
                        kext_d = ext_q;
                        rel_d  = brk_q;
                    end
                    if (!brk_q && report) begin
                        down_d  = 1'b1;
                        hcode_d = byte_q;
                        hext_d  = ext_q;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else if (brk_q && held_match) begin
                        down_d = 1'b0;
                    end
                end
            end

            // Lets the receiver's ready settle after the pop.
            S_GAP: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            byte_q  <= '0;
            rd_n_q  <= 1'b1;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            skip_q  <= '0;
            vld_q   <= 1'b0;
            code_q  <= '0;
            kext_q  <= 1'b0;
            rel_q   <= 1'b0;
            down_q  <= 1'b0;
            hcode_q <= '0;
            hext_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            rd_n_q  <= rd_n_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            skip_q  <= skip_d;
            vld_q   <= vld_d;
            code_q  <= code_d;
            kext_q  <= kext_d;
            rel_q   <= rel_d;
            down_q  <= down_d;
            hcode_q <= hcode_d;
            hext_q  <= hext_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign kb_read_n   = rd_n_q;
    assign key_valid   = vld_q;
    assign key_code    = code_q;
    assign key_ext     = kext_q;
    assign key_release = rel_q;
    assign key_down    = down_q;
    assign held_code   = hcode_q;
    assign press_count = cnt_q;
    assign ovf_seen    = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: self-checking bench for ps2_kbd_ctrl.
// Models the receiver FIFO and the key-event rules at byte/event level.

module tb_ps2_kbd_ctrl;

    localparam int CNT_W   = 8;
    localparam int E1_SKIP = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b1;
    logic kb_ready = 1'b0;
    logic kb_overflow = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic kb_read_n, key_valid, key_ext, key_release, key_down, ovf_seen;
    logic [7:0] key_code, held_code;
    logic [CNT_W-1:0] press_count;

    ps2_kbd_ctrl #(.E1_SKIP(E1_SKIP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .kb_data(kb_data), .kb_ready(kb_ready), .kb_overflow(kb_overflow),
        .kb_read_n(kb_read_n), .key_valid(key_valid), .key_code(key_code),
        .key_ext(key_ext), .key_release(key_release), .key_down(key_down),
        .held_code(held_code), .press_count(press_count),
        .ovf_seen(ovf_seen)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo[$];
    logic [9:0] obs[$];
    logic [9:0] exq[$];
    int pop_cyc[$];
    int cyc = 0;
    int last_pop = -10;
    int lat_bad = 0;
    int proto_bad = 0;
    bit rn_low = 0;
    bit prev_low = 0;
    int n_chk = 0;
    int n_fail = 0;

    int m_skip, m_cnt;
    bit m_ext, m_brk, m_down, m_hext;
    logic [7:0] m_hcode;

    task automatic model_reset();
        m_skip = 0; m_cnt = 0;
        m_ext = 0; m_brk = 0; m_down = 0; m_hext = 0;
        m_hcode = 8'h00;
        obs.delete(); exq.delete(); pop_cyc.delete();
    endtask

    // Event-level key rules applied to each byte the FIFO gives up.
    task automatic model_byte(input logic [7:0] b);
        bit keep;
        if (m_skip > 0) m_skip--;
        else if (b == 8'hE1) begin m_skip = E1_SKIP; m_ext = 0; m_brk = 0; end
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (m_brk) begin
                exq.push_back({m_ext, 1'b1, b});
                if (m_down && m_hcode == b && m_hext == m_ext) m_down = 0;
            end else begin
                keep = 1;
`ifdef PS2_TYPEMATIC_FILTER_EN
                keep = !(m_down && m_hcode == b && m_hext == m_ext);
`endif
                if (keep) begin
                    exq.push_back({m_ext, 1'b0, b});
                    m_cnt++;
                    m_down = 1; m_hcode = b; m_hext = m_ext;
                end
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    // Receiver FIFO: pops on the edge that ends a low read_n cycle.
    initial forever begin
        @(posedge clk); #1;
        cyc++;
        if (rst_n && rn_low) begin
            if (fifo.size() == 0) proto_bad++;
            else begin
                model_byte(fifo[0]);
                void'(fifo.pop_front());
            end
            last_pop = cyc;
            pop_cyc.push_back(cyc);
        end
        rn_low = 0;
        kb_ready = (fifo.size() != 0);
        if (kb_ready) kb_data = fifo[0];
        else kb_data = 8'h00;
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (!kb_read_n) begin
                if (prev_low) proto_bad++;
                rn_low = 1;
            end
            prev_low = !kb_read_n;
            if (key_valid) begin
                obs.push_back({key_ext, key_release, key_code});
                if (cyc != last_pop) lat_bad++;
            end
        end else prev_low = 0;
    end

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        kb_ready = 1'b1;
        kb_data = fifo[0];
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fifo.size() == 0) begin ok = 1; break; end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rn_low = 0; prev_low = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bit ok, found;
        #1 rst_n = 1'b0;
        model_reset();
        #2;
        n_chk++;
        if ({kb_read_n, key_valid, key_code, key_ext, key_release, key_down,
             held_code, press_count, ovf_seen} !== {1'b1, 29'h0}) begin
            n_fail++;
            $display("FAIL reset_init got rd_n=%b vld=%b cnt=%h down=%b want rd_n=1 rest 0",
                     kb_read_n, key_valid, press_count, key_down);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push(8'h1C); push(8'hE0);
        drain(100, ok);
        n_chk++;
        if (!ok || key_down !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_down got %b want 1 (drained=%0d)", key_down, ok);
        end
        push(8'h5A);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!kb_read_n) begin found = 1; break; end
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL reset_popwait got no pop want pop within 20 cycles");
        end
        #2 rst_n = 1'b0;
        rn_low = 0; prev_low = 0;
        #1;
        n_chk++;
        if ({kb_read_n, key_valid, key_code, key_ext, key_release, key_down,
             held_code, press_count, ovf_seen} !== {1'b1, 29'h0}) begin
            n_fail++;
            $display("FAIL reset_midpop got rd_n=%b down=%b cnt=%h want rd_n=1 rest 0",
                     kb_read_n, key_down, press_count);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drain(100, ok);
        n_chk++;
        if (obs.size() != 1 || !ok) begin
            n_fail++;
            $display("FAIL reset_after_nev got %0d want 1", obs.size());
        end else begin
            n_chk++;
            if (obs[0] !== 10'h05A) begin
                n_fail++;
                $display("FAIL reset_after_ev got %h want 05A", obs[0]);
            end
        end
        n_chk++;
        if (press_count !== 8'd1) begin
            n_fail++;
            $display("FAIL reset_after_cnt got %0d want 1", press_count);
        end
    endtask

    task automatic test_simple();
        bit ok;
        do_reset();
        push(8'h1C); push(8'hF0); push(8'h1C);
        drain(100, ok);
        n_chk++;
        if (obs.size() != 2 || !ok) begin
            n_fail++;
            $display("FAIL simple_nev got %0d want 2", obs.size());
        end else begin
            n_chk++;
            if (obs[0] !== 10'h01C) begin
                n_fail++;
                $display("FAIL simple_make got %h want 01C", obs[0]);
            end
            n_chk++;
            if (obs[1] !== 10'h11C) begin
                n_fail++;
                $display("FAIL simple_break got %h want 11C", obs[1]);
            end
        end
        n_chk++;
        if (key_down !== 1'b0 || press_count !== 8'd1) begin
            n_fail++;
            $display("FAIL simple_state got down=%b cnt=%0d want down=0 cnt=1",
                     key_down, press_count);
        end
        n_chk++;
        if (pop_cyc.size() != 3) begin
            n_fail++;
            $display("FAIL simple_pops got %0d want 3", pop_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_chk++;
                if (pop_cyc[i] - pop_cyc[i-1] != 3) begin
                    n_fail++;
                    $display("FAIL simple_spacing got %0d want 3",
                             pop_cyc[i] - pop_cyc[i-1]);
                end
            end
        end
        n_chk++;
        if (proto_bad != 0 || lat_bad != 0) begin
            n_fail++;
            $display("FAIL simple_proto got proto=%0d lat=%0d want 0 0",
                     proto_bad, lat_bad);
        end
    endtask

    task automatic test_extended();
        bit ok;
        do_reset();
        push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
        drain(100, ok);
        n_chk++;
        if (obs.size() != 2 || !ok) begin
            n_fail++;
            $display("FAIL ext_nev got %0d want 2", obs.size());
        end else begin
            n_chk++;
            if (obs[0] !== 10'h275 || obs[1] !== 10'h375) begin
                n_fail++;
                $display("FAIL ext_events got %h %h want 275 375", obs[0], obs[1]);
            end
        end
        n_chk++;
        if (key_down !== 1'b0) begin
            n_fail++;
            $display("FAIL ext_down got %b want 0", key_down);
        end
    endtask

    task automatic test_pause();
        bit ok;
        logic [7:0] seq [9];
        logic [CNT_W-1:0] c0;
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
        c0 = press_count;
        obs.delete(); exq.delete();
        foreach (seq[i]) push(seq[i]);
        drain(200, ok);
        n_chk++;
        if (obs.size() != 1 || !ok) begin
            n_fail++;
            $display("FAIL pause_nev got %0d want 1", obs.size());
        end else begin
            n_chk++;
            if (obs[0] !== 10'h01C) begin
                n_fail++;
                $display("FAIL pause_ev got %h want 01C", obs[0]);
            end
        end
        n_chk++;
        if (press_count !== c0 + 8'd1) begin
            n_fail++;
            $display("FAIL pause_cnt got %0d want %0d", press_count, c0 + 8'd1);
        end
    endtask

    task automatic test_repeat();
        bit ok;
        int want;
        do_reset();
        push(8'h1C); push(8'h1C); push(8'h1C);
        drain(100, ok);
`ifdef PS2_TYPEMATIC_FILTER_EN
        want = 1;
`else
        want = 3;
`endif
        n_chk++;
        if (obs.size() != want || !ok) begin
            n_fail++;
            $display("FAIL repeat_nev got %0d want %0d", obs.size(), want);
        end
        n_chk++;
        if (press_count !== CNT_W'(want) || fifo.size() != 0) begin
            n_fail++;
            $display("FAIL repeat_cnt got %0d want %0d", press_count, want);
        end
    endtask

    task automatic test_en();
        bit ok;
        int lows = 0;
        do_reset();
        @(negedge clk);
        en = 1'b0;
        push(8'h2B);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!kb_read_n) lows++;
        end
        n_chk++;
        if (lows != 0 || fifo.size() != 1) begin
            n_fail++;
            $display("FAIL en_hold got lows=%0d fifo=%0d want 0 1", lows, fifo.size());
        end
        en = 1'b1;
        drain(100, ok);
        n_chk++;
        if (obs.size() != 1 || !ok) begin
            n_fail++;
            $display("FAIL en_resume got %0d want 1 event", obs.size());
        end else begin
            n_chk++;
            if (obs[0] !== 10'h02B) begin
                n_fail++;
                $display("FAIL en_ev got %h want 02B", obs[0]);
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        for (int i = 0; i < 256; i++) push((i % 2) ? 8'h11 : 8'h10);
        drain(1200, ok);
        n_chk++;
        if (press_count !== 8'd0 || !ok) begin
            n_fail++;
            $display("FAIL wrap_cnt got %0d want 0", press_count);
        end
        n_chk++;
        if (obs.size() != 256) begin
            n_fail++;
            $display("FAIL wrap_nev got %0d want 256", obs.size());
        end
    endtask

    task automatic test_ovf();
        @(negedge clk);
        kb_overflow = 1'b1;
        @(negedge clk);
        kb_overflow = 1'b0;
        n_chk++;
        if (ovf_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set got %b want 1", ovf_seen);
        end
        repeat (6) @(negedge clk);
        n_chk++;
        if (ovf_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky got %b want 1", ovf_seen);
        end
        do_reset();
        @(negedge clk);
        n_chk++;
        if (ovf_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear got %b want 0", ovf_seen);
        end
    endtask

    task automatic test_random();
        bit ok;
        int r;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            if (r < 3) push(8'hE0);
            else if (r < 6) push(8'hF0);
            else if (r == 6) push(8'hE1);
            else if (r < 12) push(8'h10 + 8'($urandom_range(0, 3)));
            else push(8'($urandom_range(0, 255)));
            en = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        en = 1'b1;
        drain(5000, ok);
        n_chk++;
        if (obs.size() != exq.size() || !ok) begin
            n_fail++;
            $display("FAIL rand_nev got %0d want %0d", obs.size(), exq.size());
        end else begin
            foreach (obs[i]) begin
                n_chk++;
                if (obs[i] !== exq[i]) begin
                    n_fail++;
                    $display("FAIL rand_ev%0d got %h want %h", i, obs[i], exq[i]);
                end
            end
        end
        n_chk++;
        if (press_count !== CNT_W'(m_cnt) || key_down !== m_down ||
            held_code !== m_hcode) begin
            n_fail++;
            $display("FAIL rand_state got cnt=%0d down=%b held=%h want %0d %b %h",
                     press_count, key_down, held_code, CNT_W'(m_cnt), m_down, m_hcode);
        end
        n_chk++;
        if (proto_bad != 0 || lat_bad != 0) begin
            n_fail++;
            $display("FAIL rand_proto got proto=%0d lat=%0d want 0 0",
                     proto_bad, lat_bad);
        end
    endtask

    initial begin
        test_reset();
        test_simple();
        test_extended();
        test_pause();
        test_repeat();
        test_en();
        test_wrap();
        test_ovf();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
- Sequencer on the read side of the PS/2 keyboard receiver FIFO.
- Pops scan-code bytes using the receiver's ready/read_n handshake and assembles make/break/extended (E0/F0) sequences into single key events.
- Tracks the currently held key and counts key presses.
- Sits between the receiver and the consumer logic (display/CPU MMIO).

Parameters:
- E1_SKIP, 7: number of bytes dropped after an E1 (Pause) prefix byte.
- CNT_W, 8: width of press_count.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- en  in  1  1 = controller may pop receiver bytes; 0 = hold off; decode state kept
- kb_data  in  8  receiver FIFO head byte; valid while kb_ready=1
- kb_ready  in  1  receiver FIFO non-empty
- kb_overflow  in  1  receiver sticky overflow flag
- kb_read_n  out  1  active-low pop strobe to receiver; registered
- key_valid  out  1  one-cycle pulse: key event outputs valid
- key_code  out  8  scan code of the event (prefixes stripped)
- key_ext  out  1  event carried E0 prefix
- key_release  out  1  1 = break event, 0 = make event
- key_down  out  1  a key is currently held (held_code/held_ext valid)
- held_code  out  8  scan code of the held key
- press_count  out  CNT_W  number of reported make events, modulo 2^CNT_W
- ovf_seen  out  1  sticky: kb_overflow was observed high since reset

Behaviour:
- Reset values (async, rst_n=0):
  - kb_read_n=1, key_valid=0, key_code=0, key_ext=0, key_release=0, key_down=0, held_code=0, press_count=0, ovf_seen=0.
  - FSM=IDLE; ext/brk flags and E1 skip counter cleared.
  - Reset mid-sequence discards any partial prefix state.
- FSM states and transitions:
  - IDLE: if en=1 and kb_ready=1 at edge T, latch byte<=kb_data, kb_read_n<=0, go to POP.
  - POP: kb_read_n is low for exactly one cycle. At edge T+1: kb_read_n<=1, decode the byte, go to GAP.
  - GAP: one wait cycle so the receiver's ready reflects the pop. At T+2, go to IDLE.
  - Never pop with kb_ready=0. Never hold kb_read_n low for two consecutive cycles.
- Throughput: one byte per 3 cycles.
- Event latency: key_valid is high in the cycle after edge T+1, i.e. registered at T+1 and high for exactly one cycle.
- Decode (at T+1):
  - E1 skip counter nonzero: decrement; no other effect.
  - Byte E1: skip counter<=E1_SKIP; clear ext/brk.
  - Byte E0: ext<=1.
  - Byte F0: brk<=1.
  - Any other byte completes an event: key_code=byte, key_ext=ext, key_release=brk, key_valid pulse; ext and brk then cleared.
  - F0 before E0 (F0 E0 xx) is accepted; both flags apply.
- Held-key tracking:
  - Make event: key_down<=1, held_code<=code, held ext<=ext. A new make overrides the previous held key.
  - Break event matching held_code and held ext: key_down<=0.
  - Non-matching break: held state unchanged; event still reported.
- press_count: +1 on each reported make event; wraps from all-ones to 0.
- en deasserted:
  - In IDLE: no pop.
  - In POP/GAP: the current sequence completes.
- ovf_seen: set the first cycle kb_overflow=1; cleared only by reset.

Optional Feature:
- PS2_TYPEMATIC_FILTER_EN
- Defined: a make event with code/ext equal to the held key while key_down=1 (auto-repeat) produces no key_valid and no press_count increment. The byte is still popped.
- Undefined: every make is reported and counted.

Test Plan:
- Reset: rst_n=0 asynchronously mid-POP -> kb_read_n=1 and all outputs 0 immediately; after release, FSM in IDLE.
- Simple key: FIFO bytes 1C, F0, 1C ->
  - first event key_code=1C, release=0, key_down=1, press_count=1;
  - second event key_code=1C, release=1, key_down=0;
  - exactly 3 kb_read_n pulses, each 1 cycle, 3 cycles apart.
- Extended: E0, 75, E0, F0, 75 -> events (75, ext=1, make) and (75, ext=1, break); no events for the prefix bytes.
- Pause: E1 14 77 E1 F0 14 F0 77 then 1C -> only one event, 1C make. press_count increments by 1.
- Auto-repeat: 1C, 1C, 1C ->
  - with PS2_TYPEMATIC_FILTER_EN: 1 event, press_count=1;
  - without it: 3 events, press_count=3.
- Flow/boundary:
  - en=0 with kb_ready=1 -> kb_read_n stays 1;
  - 256 makes -> press_count wraps to 0;
  - kb_overflow pulse -> ovf_seen=1 until reset.
